// File: rtl/boot_pkg.sv
// -----------------------------------------------------------------------------
// boot_pkg
// Shared definitions for the UART boot sequencer: FSM state encoding,
// error-code values reported on err_code, and the default frame start byte.
// -----------------------------------------------------------------------------
package boot_pkg;

   typedef enum logic [2:0] {
      S_HDR  = 3'd0,
      S_LEN  = 3'd1,
      S_DATA = 3'd2,
      S_CSUM = 3'd3,
      S_RUN  = 3'd4,
      S_ERR  = 3'd5
   } state_t;

   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_LEN  = 2'd1;
   localparam logic [1:0] ERR_CSUM = 2'd2;
   localparam logic [1:0] ERR_RX   = 2'd3;

   localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/boot_word_packer.sv
// -----------------------------------------------------------------------------
// boot_word_packer
// Assembles little-endian 32-bit words from a byte stream. Bytes 0..2 collect
// in a staging register; the 4th byte moves the completed word into a separate
// output buffer, so a byte arriving while the buffer is being written to
// memory lands in the free staging register and is never lost.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   clear      in   restart at byte 0 (new frame)
//   byte_vld   in   accept byte_data this cycle
//   byte_data  in   [7:0] payload byte
//   byte_idx   out  [1:0] index of the next byte within the word
//   word       out  [31:0] last completed word (held until the next one)
//   word_rdy   out  one-cycle strobe, word holds a freshly completed word
// -----------------------------------------------------------------------------
module boot_word_packer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        byte_vld,
   input  logic [7:0]  byte_data,
   output logic [1:0]  byte_idx,
   output logic [31:0] word,
   output logic        word_rdy
);

   logic [23:0] stage;

   // Staging bytes carry no control meaning, so they are left unreset.
   always_ff @(posedge clk) begin
      if (byte_vld) begin
         case (byte_idx)
            2'd0:    stage[7:0]   <= byte_data;
            2'd1:    stage[15:8]  <= byte_data;
            2'd2:    stage[23:16] <= byte_data;
            default: stage        <= stage;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         byte_idx <= 2'd0;
         word     <= 32'd0;
         word_rdy <= 1'b0;
      end else begin
         word_rdy <= 1'b0;
         if (clear) begin
            byte_idx <= 2'd0;
         end else if (byte_vld) begin
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
               word     <= {byte_data, stage};
               word_rdy <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/uart_boot_sequencer.sv
// -----------------------------------------------------------------------------
// uart_boot_sequencer
// Loads a program image received over UART into instruction memory and holds
// the CPU in reset until a checksum-verified image is in place.
// Frame: HDR_BYTE, N (words), N*4 payload bytes little-endian, XOR checksum.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   boot_en               1 = load before run, 0 = run immediately
//   rx_valid, rx_data     received byte strobe and data
//   rx_err                UART framing error strobe (wins over rx_valid)
//   imem_we/addr/wdata    instruction memory write port
//   cpu_hold              1 = keep CPU in reset
//   boot_done             verified image loaded, CPU running
//   boot_err, err_code    sticky error flag and cause (see boot_pkg)
//
// Build option: define BOOT_TIMEOUT_EN to abort a load that stalls for
// TIMEOUT_CYCLES without a byte (err_code = ERR_RX). Without it a stalled
// load waits indefinitely.
// -----------------------------------------------------------------------------
module uart_boot_sequencer
   import boot_pkg::*;
#(
   parameter int         INSTR_MEM_DEPTH = 128,
   parameter int         ADDR_W          = $clog2(INSTR_MEM_DEPTH),
   parameter logic [7:0] HDR_BYTE        = HDR_BYTE_DEFAULT,
   parameter int         TIMEOUT_CYCLES  = 1000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              boot_en,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   input  logic              rx_err,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              boot_done,
   output logic              boot_err,
   output logic [1:0]        err_code
);

   localparam logic [8:0] DEPTH9 = 9'(INSTR_MEM_DEPTH);

   state_t            state;
   logic [7:0]        len;
   logic [7:0]        csum;
   logic [ADDR_W-1:0] word_idx;
   logic [1:0]        byte_idx;
   logic              byte_ok;
   logic              is_hdr;
   logic              pk_vld;
   logic              pk_clr;
   logic              expire;
   logic [8:0]        word_num;

   // A framing error discards any byte presented in the same cycle.
   assign byte_ok  = rx_valid & ~rx_err;
   assign is_hdr   = byte_ok && (rx_data == HDR_BYTE);
   assign pk_vld   = byte_ok && (state == S_DATA);
   assign pk_clr   = byte_ok && (state == S_LEN);
   assign word_num = 9'(word_idx) + 9'd1;

   boot_word_packer u_packer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (pk_clr),
      .byte_vld  (pk_vld),
      .byte_data (rx_data),
      .byte_idx  (byte_idx),
      .word      (imem_wdata),
      .word_rdy  (imem_we)
   );

`ifdef BOOT_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic            loading;
   logic [TO_W-1:0] to_cnt;

   assign loading = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
   // A byte in the expiry cycle wins over the timeout.
   assign expire  = loading && !byte_ok && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         to_cnt <= '0;
      end else if (!loading || byte_ok || expire) begin
         to_cnt <= '0;
      end else begin
         to_cnt <= to_cnt + 1'b1;
      end
   end
`else
   logic unused_timeout;

   assign unused_timeout = ^TIMEOUT_CYCLES;
   assign expire         = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_HDR;
         cpu_hold  <= 1'b1;
         boot_done <= 1'b0;
         boot_err  <= 1'b0;
         err_code  <= ERR_NONE;
         len       <= 8'd0;
         csum      <= 8'd0;
         word_idx  <= '0;
         imem_addr <= '0;
      end else begin
         case (state)
            S_HDR: begin
               if (!boot_en) begin
                  state     <= S_RUN;
                  cpu_hold  <= 1'b0;
                  boot_done <= 1'b0;
               end else if (is_hdr) begin
                  state <= S_LEN;
               end
            end

            S_LEN: begin
               if (rx_err || expire) begin
                  state    <= S_ERR;
                  boot_err <= 1'b1;
                  err_code <= ERR_RX;
               end else if (byte_ok) begin
                  if ((rx_data == 8'd0) || ({1'b0, rx_data} > DEPTH9)) begin
                     state    <= S_ERR;
                     boot_err <= 1'b1;
                     err_code <= ERR_LEN;
                  end else begin
                     len       <= rx_data;
                     csum      <= 8'd0;
                     word_idx  <= '0;
                     imem_addr <= '0;
                     state     <= S_DATA;
                  end
               end
            end

            S_DATA: begin
               if (rx_err || expire) begin
                  state    <= S_ERR;
                  boot_err <= 1'b1;
                  err_code <= ERR_RX;
               end else if (byte_ok) begin
                  csum <= csum ^ rx_data;
                  // The packer raises imem_we on this same edge; the address
                  // is registered alongside so both appear together.
                  if (byte_idx == 2'd3) begin
                     imem_addr <= word_idx;
                     word_idx  <= word_idx + 1'b1;
                     if (word_num == {1'b0, len}) begin
                        state <= S_CSUM;
                     end
                  end
               end
            end

            S_CSUM: begin
               if (rx_err || expire) begin
                  state    <= S_ERR;
                  boot_err <= 1'b1;
                  err_code <= ERR_RX;
               end else if (byte_ok) begin
                  if (rx_data == csum) begin
                     state     <= S_RUN;
                     cpu_hold  <= 1'b0;
                     boot_done <= 1'b1;
                  end else begin
                     state    <= S_ERR;
                     boot_err <= 1'b1;
                     err_code <= ERR_CSUM;
                  end
               end
            end

            S_RUN: begin
               // Non-header bytes belong to the running program's UART.
               if (is_hdr) begin
                  state     <= S_LEN;
                  cpu_hold  <= 1'b1;
                  boot_done <= 1'b0;
               end
            end

            S_ERR: begin
               if (is_hdr) begin
                  state    <= S_LEN;
                  boot_err <= 1'b0;
                  err_code <= ERR_NONE;
               end
            end

            default: begin
               state    <= S_HDR;
               cpu_hold <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_boot_sequencer.sv
// -----------------------------------------------------------------------------
// tb_uart_boot_sequencer
// Directed bench for uart_boot_sequencer. Expected memory writes are queued
// when payload is sent and checked by a monitor when imem_we appears.
// Define BOOT_TIMEOUT_EN to exercise the inter-byte timeout.
// -----------------------------------------------------------------------------
module tb_uart_boot_sequencer;

   localparam int ADDR_W = 7;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              boot_en = 1'b1;
   logic              rx_valid = 1'b0;
   logic [7:0]        rx_data = 8'h00;
   logic              rx_err = 1'b0;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_hold;
   logic              boot_done;
   logic              boot_err;
   logic [1:0]        err_code;

   int          vectors = 0;
   int          miscompares = 0;
   logic [39:0] sb[$];
   logic [31:0] img[4];
   logic [7:0]  csum_m;

   uart_boot_sequencer #(
      .INSTR_MEM_DEPTH (128),
      .ADDR_W          (ADDR_W),
      .HDR_BYTE        (8'hA5),
      .TIMEOUT_CYCLES  (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .boot_en    (boot_en),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_err     (rx_err),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_hold   (cpu_hold),
      .boot_done  (boot_done),
      .boot_err   (boot_err),
      .err_code   (err_code)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Write monitor: every imem_we must match the oldest queued expectation.
   always @(negedge clk) begin
      logic [39:0] exp_wr;
      if (imem_we !== 1'b0) begin
         check("imem_we_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            exp_wr = sb.pop_front();
            check("imem_addr", 32'(imem_addr), 32'(exp_wr[39:32]));
            check("imem_wdata", imem_wdata, exp_wr[31:0]);
         end
      end
   end

   // Called at a falling edge; returns at the next falling edge, when the
   // outputs reflect the rising edge that sampled the byte.
   task automatic send_byte(input logic [7:0] b, input logic err);
      rx_valid = 1'b1;
      rx_data  = b;
      rx_err   = err;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_err   = 1'b0;
   endtask

   task automatic pulse_err();
      rx_err = 1'b1;
      @(negedge clk);
      rx_err = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Sends nbytes of img[] little-endian, queueing each completed word.
   task automatic send_payload(input int nbytes);
      logic [7:0] b;
      for (int i = 0; i < nbytes; i++) begin
         b = img[i/4][8*(i%4) +: 8];
         csum_m ^= b;
         if (i % 4 == 3) sb.push_back({8'(i/4), img[i/4]});
         send_byte(b, 1'b0);
      end
   endtask

   task automatic check_status(input string tag, input logic hold, input logic done,
                               input logic err, input logic [1:0] code);
      check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(hold));
      check({tag, "_boot_done"}, 32'(boot_done), 32'(done));
      check({tag, "_boot_err"}, 32'(boot_err), 32'(err));
      check({tag, "_err_code"}, 32'(err_code), 32'(code));
   endtask

   task automatic check_reset_state(input string tag);
      check_status(tag, 1'b1, 1'b0, 1'b0, 2'd0);
      check({tag, "_imem_we"}, 32'(imem_we), 32'd0);
      check({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
      check({tag, "_imem_wdata"}, imem_wdata, 32'd0);
   endtask

   initial begin
      // Reset with loading enabled; sequencer waits for a header.
      rst_n = 1'b0;
      boot_en = 1'b1;
      idle(3);
      check_reset_state("reset");
      rst_n = 1'b1;
      idle(4);
      check_status("hdr_wait", 1'b1, 1'b0, 1'b0, 2'd0);

      // Good two-word frame.
      img[0] = 32'h12345678;
      img[1] = 32'hDEADBEEF;
      csum_m = 8'h00;
      send_byte(8'hA5, 1'b0);
      send_byte(8'h02, 1'b0);
      send_payload(8);
      check_status("pre_csum", 1'b1, 1'b0, 1'b0, 2'd0);
      check("frame1_csum_model", 32'(csum_m), 32'h2A);
      send_byte(csum_m, 1'b0);
      check_status("run1", 1'b0, 1'b1, 1'b0, 2'd0);

      // Live reload, bad checksum, then a good three-word frame.
      send_byte(8'hA5, 1'b0);
      check_status("reload", 1'b1, 1'b0, 1'b0, 2'd0);
      csum_m = 8'h00;
      send_byte(8'h02, 1'b0);
      send_payload(8);
      send_byte(8'h00, 1'b0);
      check_status("bad_csum", 1'b1, 1'b0, 1'b1, 2'd2);
      idle(3);
      check_status("bad_csum_sticky", 1'b1, 1'b0, 1'b1, 2'd2);
      img[0] = 32'h11223344;
      img[1] = 32'hCAFEF00D;
      img[2] = 32'h80000001;
      csum_m = 8'h00;
      send_byte(8'hA5, 1'b0);
      check_status("err_clear", 1'b1, 1'b0, 1'b0, 2'd0);
      send_byte(8'h03, 1'b0);
      send_payload(12);
      send_byte(csum_m, 1'b0);
      check_status("run2", 1'b0, 1'b1, 1'b0, 2'd0);

      // Length bounds: 0 and DEPTH+1 rejected, DEPTH accepted.
      send_byte(8'hA5, 1'b0);
      send_byte(8'h00, 1'b0);
      check_status("len_zero", 1'b1, 1'b0, 1'b1, 2'd1);
      send_byte(8'hA5, 1'b0);
      send_byte(8'h81, 1'b0);
      check_status("len_over", 1'b1, 1'b0, 1'b1, 2'd1);
      send_byte(8'hA5, 1'b0);
      send_byte(8'h80, 1'b0);
      check_status("len_max", 1'b1, 1'b0, 1'b0, 2'd0);

      // rx_err after two payload bytes: abort with no write.
      send_byte(8'h01, 1'b0);
      send_byte(8'h02, 1'b0);
      pulse_err();
      check_status("rx_err", 1'b1, 1'b0, 1'b1, 2'd3);
      // Header with rx_err in ERR is discarded.
      send_byte(8'hA5, 1'b1);
      check_status("hdr_with_err", 1'b1, 1'b0, 1'b1, 2'd3);
      send_byte(8'hA5, 1'b0);
      send_byte(8'h01, 1'b0);
      check_status("len1", 1'b1, 1'b0, 1'b0, 2'd0);
      send_byte(8'h10, 1'b0);
      send_byte(8'h20, 1'b0);
      send_byte(8'h30, 1'b0);
      send_byte(8'h40, 1'b1);
      check_status("byte_with_err", 1'b1, 1'b0, 1'b1, 2'd3);
      idle(2);

      // boot_en=0: run straight after reset; header byte forces reload.
      rst_n = 1'b0;
      boot_en = 1'b0;
      idle(2);
      check_reset_state("reset2");
      rst_n = 1'b1;
      idle(2);
      check_status("direct_run", 1'b0, 1'b0, 1'b0, 2'd0);
      send_byte(8'h41, 1'b0);
      check_status("run_ignore", 1'b0, 1'b0, 1'b0, 2'd0);
      send_byte(8'hA5, 1'b0);
      check_status("run_reload", 1'b1, 1'b0, 1'b0, 2'd0);
      boot_en = 1'b1;

      // Reset in the middle of the third word.
      img[0] = 32'hA0A1A2A3;
      img[1] = 32'hB0B1B2B3;
      img[2] = 32'hC0C1C2C3;
      csum_m = 8'h00;
      send_byte(8'h03, 1'b0);
      send_payload(9);
      check("mid_addr", 32'(imem_addr), 32'd1);
      rst_n = 1'b0;
      idle(1);
      check_reset_state("reset_mid");
      rst_n = 1'b1;

      // Fresh one-word frame after the aborted load.
      img[0] = 32'h00C0FFEE;
      csum_m = 8'h00;
      send_byte(8'hA5, 1'b0);
      send_byte(8'h01, 1'b0);
      send_payload(4);
      send_byte(csum_m, 1'b0);
      check_status("run3", 1'b0, 1'b1, 1'b0, 2'd0);

      // Stall in DATA.
      img[0] = 32'h55AA33CC;
      csum_m = 8'h00;
      send_byte(8'hA5, 1'b0);
      send_byte(8'h01, 1'b0);
      send_byte(8'hCC, 1'b0);
      idle(15);
      check_status("stall15", 1'b1, 1'b0, 1'b0, 2'd0);
      send_byte(8'h33, 1'b0);
      check_status("byte_at_16", 1'b1, 1'b0, 1'b0, 2'd0);
      idle(15);
      check_status("stall15b", 1'b1, 1'b0, 1'b0, 2'd0);
      idle(1);
`ifdef BOOT_TIMEOUT_EN
      check_status("timeout", 1'b1, 1'b0, 1'b1, 2'd3);
`else
      check_status("no_timeout", 1'b1, 1'b0, 1'b0, 2'd0);
      idle(40);
      check_status("long_stall", 1'b1, 1'b0, 1'b0, 2'd0);
      sb.push_back({8'd0, img[0]});
      send_byte(8'hAA, 1'b0);
      send_byte(8'h55, 1'b0);
      send_byte(8'hCC ^ 8'h33 ^ 8'hAA ^ 8'h55, 1'b0);
      check_status("run_after_stall", 1'b0, 1'b1, 1'b0, 2'd0);
`endif

      idle(3);
      check("pending_writes", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
